// File: rtl/core_pkg.sv
// Core-wide widths shared by the fetch front end and decode.
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
endpackage

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues PC-register addresses to instruction memory and returns
// responses to decode in order, discarding fetches that a taken branch/jump has made stale.
module ifetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            fetch_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  input  logic            inst_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [XLEN-1:0]  pc_r   [DEPTH];
  logic [XLEN-1:0]  data_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [DEPTH-1:0] filled_nx_s;
  logic [PW-1:0]    alloc_ptr_r;
  logic [PW-1:0]    fill_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    drop_cnt_r;
  logic [PW-1:0]    occ_s;
  logic [IW-1:0]    alloc_idx_s;
  logic [IW-1:0]    fill_idx_s;
  logic [IW-1:0]    rd_idx_s;
  logic             credit_s;
  logic             rsp_take_s;
  logic             pop_s;

  assign alloc_idx_s   = alloc_ptr_r[IW-1:0];
  assign fill_idx_s    = fill_ptr_r[IW-1:0];
  assign rd_idx_s      = rd_ptr_r[IW-1:0];
  assign imem_req_addr = fetch_addr;
  assign inst_pc       = pc_r[rd_idx_s];
  assign inst_data     = data_r[rd_idx_s];

  // Credit counts stale in-flight fetches too, so a flushed response always has a slot to drain from.
  always_comb begin
    occ_s          = (alloc_ptr_r - rd_ptr_r) + drop_cnt_r;
    credit_s       = (occ_s < PW'(DEPTH));
    imem_req_valid = rst_n & fetch_valid & credit_s & ~flush;
    fetch_ready    = imem_req_valid & imem_req_ready;
    inst_valid     = filled_r[rd_idx_s] & (rd_ptr_r != fill_ptr_r) & ~flush;
    pop_s          = inst_valid & inst_ready;
    rsp_take_s     = imem_rsp_valid & (drop_cnt_r == '0) & ~flush;
  end

  // Next filled bits: allocate clears, response sets, pop clears; indices never collide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      filled_nx_s[i] = (filled_r[i] | (rsp_take_s & (fill_idx_s == IW'(i))))
                     & ~(fetch_ready & (alloc_idx_s == IW'(i)))
                     & ~(pop_s & (rd_idx_s == IW'(i)));
    end
  end

  // Pointers, drop counter and filled bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      rd_ptr_r    <= '0;
      drop_cnt_r  <= '0;
      filled_r    <= '0;
    end else if (flush) begin
      // Every unanswered fetch becomes stale; a response arriving now is itself discarded.
      drop_cnt_r <= drop_cnt_r + (alloc_ptr_r - fill_ptr_r) - {{(PW-1){1'b0}}, imem_rsp_valid};
      fill_ptr_r <= alloc_ptr_r;
      rd_ptr_r   <= alloc_ptr_r;
      filled_r   <= '0;
    end else begin
      filled_r <= filled_nx_s;
      if (fetch_ready) begin
        alloc_ptr_r <= alloc_ptr_r + PW'(1);
      end
      if (imem_rsp_valid) begin
        if (drop_cnt_r != '0) begin
          drop_cnt_r <= drop_cnt_r - PW'(1);
        end else begin
          fill_ptr_r <= fill_ptr_r + PW'(1);
        end
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry payload storage, unreset: filled bits alone qualify the contents.
  always_ff @(posedge clk) begin
    if (fetch_ready) begin
      pc_r[alloc_idx_s] <= fetch_addr;
    end
    if (rsp_take_s) begin
      data_r[fill_idx_s] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic
// against a queue-level model of fetch, in-order memory responses and flush.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fetch_valid = 1'b0;
  logic [XLEN-1:0] fetch_addr = '0;
  logic            fetch_ready;
  logic            flush = 1'b0;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b0;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;
  logic            inst_ready = 1'b0;

  ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } ment_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;

  ment_t       mq[$];        // live entries, oldest first
  mreq_t       mem[$];       // memory requests awaiting a response, in order
  logic [31:0] popped[$];
  logic [31:0] accepted[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_due = -1;
  int lat_min = 1;
  int lat_max = 1;
  logic [31:0] pc = '0;
  logic [31:0] flush_target = '0;
  bit fv, fl, rr, ir;
  int p0, a0;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model, wait for next posedge+1.
  task automatic step();
    bit          rsp, e_req, e_acc, e_iv;
    logic [31:0] rdata;
    int          stale_n, occ, lat, due;
    mreq_t       m;
    ment_t       e;
    rsp     = (mem.size() > 0) && (mem[0].due == cyc);
    rdata   = rsp ? dfun(mem[0].addr) : $urandom;
    stale_n = 0;
    foreach (mem[i]) if (mem[i].stale) stale_n++;
    occ   = mq.size() + stale_n;
    e_req = fv && !fl && (occ < DEPTH);
    e_acc = e_req && rr;
    e_iv  = !fl && (mq.size() > 0) && mq[0].filled;
    fetch_valid    = fv;
    fetch_addr     = pc;
    flush          = fl;
    imem_req_ready = rr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    inst_ready     = ir;
    @(negedge clk);
    chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
    chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, e_acc});
    chk("imem_req_addr", imem_req_addr, pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, e_iv});
    if (e_iv) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_data", inst_data, mq[0].data);
    end
    if (e_iv && ir) begin
      popped.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    if (rsp) begin
      m = mem.pop_front();
      if (!m.stale && !fl) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].filled) begin
            mq[i].data   = dfun(m.addr);
            mq[i].filled = 1'b1;
            break;
          end
        end
      end
    end
    if (fl) begin
      mq.delete();
      foreach (mem[i]) mem[i].stale = 1'b1;
      pc = flush_target;
    end
    if (e_acc) begin
      accepted.push_back(pc);
      e.pc = pc; e.data = '0; e.filled = 1'b0;
      mq.push_back(e);
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      m.addr = pc; m.due = due; m.stale = 1'b0;
      mem.push_back(m);
      pc = pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    int k;
    fv = 1'b0; fl = 1'b0; rr = 1'b1; ir = 1'b1;
    k = 0;
    while ((mq.size() > 0 || mem.size() > 0) && k < 60) begin
      step();
      k++;
    end
    checks++;
    if (mq.size() > 0 || mem.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 cycle=%0d", mq.size() + mem.size(), cyc);
    end
  endtask

  initial begin
    fetch_valid = 1'b1;
    #2;
    chk("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming, 1-cycle memory
    lat_min = 1; lat_max = 1;
    fv = 1'b1; fl = 1'b0; rr = 1'b1; ir = 1'b1; pc = 32'h0;
    p0 = popped.size();
    run(12);
    chk("stream_pops", popped.size() - p0, 32'd10);
    for (int k = 0; k < 10; k++) chk("stream_pc", popped[p0 + k], 32'(4 * k));

    // Back-pressure: exactly DEPTH accepts, one pop reopens one credit
    drain();
    ir = 1'b0; fv = 1'b1;
    a0 = accepted.size();
    run(8);
    chk("bp_accepts", accepted.size() - a0, 32'd4);
    ir = 1'b1;
    a0 = accepted.size();
    step();
    chk("bp_pop_cycle_accepts", accepted.size() - a0, 32'd0);
    ir = 1'b0;
    run(4);
    chk("bp_reopen_accepts", accepted.size() - a0, 32'd1);

    // Flush with three fetches in flight
    drain();
    lat_min = 4; lat_max = 4; pc = 32'h100; fv = 1'b1;
    run(3);
    fv = 1'b0; fl = 1'b1; flush_target = 32'h200;
    step();
    fl = 1'b0; fv = 1'b1;
    p0 = popped.size();
    run(12);
    chk("flush3_first_pc", popped[p0], 32'h200);

    // Flush coinciding with a response and inst_ready
    drain();
    lat_min = 2; lat_max = 2; pc = 32'h0; fv = 1'b1;
    run(6);
    fl = 1'b1; flush_target = 32'h300;
    p0 = popped.size();
    step();
    chk("flush_no_pop", popped.size() - p0, 32'd0);
    fl = 1'b0;
    run(8);
    chk("flush_rsp_first_pc", popped[p0], 32'h300);

    // Memory not ready for 5 cycles
    drain();
    lat_min = 1; lat_max = 1; rr = 1'b0; fv = 1'b1; pc = 32'h400;
    a0 = accepted.size();
    run(5);
    chk("stall_accepts", accepted.size() - a0, 32'd0);
    rr = 1'b1;
    run(2);
    chk("stall_first", accepted[a0], 32'h400);
    chk("stall_second", accepted[a0 + 1], 32'h404);

    // Reset mid-stream with two filled entries
    drain();
    ir = 1'b0; fv = 1'b1; pc = 32'h600;
    run(2);
    fv = 1'b0;
    run(2);
    chk("pre_reset_filled", mq.size(), 32'd2);
    fetch_valid = 1'b1; imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    mq.delete(); mem.delete(); last_due = -1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    pc = 32'h500; fv = 1'b1; ir = 1'b1;
    p0 = popped.size();
    run(1);
    chk("post_reset_entry0", dut.pc_r[0], 32'h500);
    run(4);
    chk("post_reset_first_pc", popped[p0], 32'h500);

    // Randomized traffic
    for (int b = 0; b < 6; b++) begin
      int pf, pr, pi, pfl;
      pf = 50 + 10 * b; pr = 40 + 12 * b; pi = 90 - 12 * b; pfl = 2 + b;
      lat_min = 1; lat_max = 1 + (b % 4);
      for (int k = 0; k < 500; k++) begin
        fv = ($urandom_range(99, 0) < pf);
        rr = ($urandom_range(99, 0) < pr);
        ir = ($urandom_range(99, 0) < pi);
        fl = ($urandom_range(99, 0) < pfl);
        flush_target = $urandom & 32'hFFFF_FFFC;
        step();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
